// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared FSM state, 7-segment codes and segment decoder for result_display
package calc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  // Patterns are {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  localparam int unsigned BIN_W     = 8;
  localparam int unsigned BCD_W     = 12;
  localparam int unsigned ITER_LAST = BIN_W - 1;

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble, input logic blank);
    logic [6:0] pat;
    if (blank) begin
      pat = SEG_BLANK;
    end else begin
      case (nibble)
        4'd0:    pat = SEG_0;
        4'd1:    pat = SEG_1;
        4'd2:    pat = SEG_2;
        4'd3:    pat = SEG_3;
        4'd4:    pat = SEG_4;
        4'd5:    pat = SEG_5;
        4'd6:    pat = SEG_6;
        4'd7:    pat = SEG_7;
        4'd8:    pat = SEG_8;
        4'd9:    pat = SEG_9;
        default: pat = SEG_BLANK;
      endcase
    end
    return pat;
  endfunction

endpackage

// File: rtl/result_display_if.sv
// rtl/result_display_if.sv - conversion request/result and display pin bundle for result_display
interface result_display_if;
  logic [7:0]  result_i;
  logic        load_i;
  logic        busy_o;
  logic        bcd_valid_o;
  logic [11:0] bcd_o;
  logic [6:0]  seg_o;
  logic [3:0]  an_o;

  modport master (
    output result_i,
    output load_i,
    input  busy_o,
    input  bcd_valid_o,
    input  bcd_o,
    input  seg_o,
    input  an_o
  );

  modport slave (
    input  result_i,
    input  load_i,
    output busy_o,
    output bcd_valid_o,
    output bcd_o,
    output seg_o,
    output an_o
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble 8-bit to 3-digit BCD converter
// OVF_INDICATOR_EN adds an overflow flag register set when the converted value is 255.
module bin2bcd_seq
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  result,
  input  logic        load,
  output logic        busy,
  output logic        bcd_valid,
  output logic [11:0] bcd
`ifdef OVF_INDICATOR_EN
  ,
  output logic        ovf
`endif
);

  conv_state_t state_q, state_d;
  logic [7:0]  bin_q, bin_d;
  logic [11:0] scratch_q, scratch_d;
  logic [2:0]  iter_q, iter_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [11:0] bcd_q, bcd_d;
  logic [11:0] adj;
`ifdef OVF_INDICATOR_EN
  logic        ovf_q, ovf_d;
`endif

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign adj = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    iter_d    = iter_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    bcd_d     = bcd_q;
`ifdef OVF_INDICATOR_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          bin_d     = result;
          scratch_d = '0;
          iter_d    = '0;
          busy_d    = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Adjust-then-shift of the combined {scratch,bin} register
        scratch_d = {adj[10:0], bin_q[7]};
        bin_d     = {bin_q[6:0], 1'b0};
        iter_d    = iter_q + 3'd1;
        if (iter_q == 3'(ITER_LAST)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_d   = scratch_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
`ifdef OVF_INDICATOR_EN
        ovf_d   = (scratch_q == 12'h255);
`endif
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      bcd_q     <= '0;
`ifdef OVF_INDICATOR_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      iter_q    <= iter_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      bcd_q     <= bcd_d;
`ifdef OVF_INDICATOR_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign bcd_valid = valid_q;
  assign bcd       = bcd_q;
`ifdef OVF_INDICATOR_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: rtl/result_display.sv
// rtl/result_display.sv - BCD conversion of the calculator result and 4-digit multiplexed 7-segment drive
// OVF_INDICATOR_EN shows 'E' on digit 3 when the held value is 255.
module result_display
  import calc_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input logic          clk,
  input logic          rst_n,
  result_display_if.slave bus
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [11:0]      bcd;
  logic [CNT_W-1:0] refresh_cnt;
  logic             wrap;
  logic [1:0]       digit_idx;
  logic [6:0]       seg_q, seg_next;
  logic [3:0]       an_q, an_next;
  logic             blank_h, blank_t;
`ifdef OVF_INDICATOR_EN
  logic             ovf;
`endif

  bin2bcd_seq u_conv (
    .clk       (clk),
    .rst_n     (rst_n),
    .result    (bus.result_i),
    .load      (bus.load_i),
    .busy      (bus.busy_o),
    .bcd_valid (bus.bcd_valid_o),
    .bcd       (bcd)
`ifdef OVF_INDICATOR_EN
    ,
    .ovf       (ovf)
`endif
  );

  assign wrap    = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));
  assign blank_h = (bcd[11:8] == 4'd0);
  assign blank_t = blank_h && (bcd[7:4] == 4'd0);

  // Pattern for the slot about to be driven on the next wrap
  always_comb begin
    seg_next = SEG_BLANK;
    an_next  = ~(4'b0001 << digit_idx);
    case (digit_idx)
      2'd0: seg_next = seg_decode(bcd[3:0], 1'b0);
      2'd1: seg_next = seg_decode(bcd[7:4], blank_t);
      2'd2: seg_next = seg_decode(bcd[11:8], blank_h);
      default: begin
`ifdef OVF_INDICATOR_EN
        seg_next = ovf ? SEG_E : SEG_BLANK;
`else
        seg_next = SEG_BLANK;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
      seg_q       <= SEG_BLANK;
      an_q        <= 4'hF;
    end else begin
      if (wrap) begin
        refresh_cnt <= '0;
        digit_idx   <= digit_idx + 2'd1;
        seg_q       <= seg_next;
        an_q        <= an_next;
      end else begin
        refresh_cnt <= refresh_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.bcd_o = bcd;
  assign bus.seg_o = seg_q;
  assign bus.an_o  = an_q;

endmodule
